// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N-to-1 registered selector; explicit select (mode=0) or round-robin arbitration (mode=1).
// Latency: one cycle from an input transfer to out_valid/out_data/out_src.
// Backpressure: out_valid & ~out_ready freezes the output word and holds every in_ready low.
// Optional: define MUX_RR_LOCK_EN to add the lock input, which pins round-robin to the last-granted channel.
module mux_rr_arb #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             mode,
    input  logic [SEL_WIDTH-1:0]             sel,
`ifdef MUX_RR_LOCK_EN
    input  logic                             lock,
`endif
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    output logic [NUM_INPUTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SEL_WIDTH-1:0]             out_src,
    output logic                             out_valid,
    input  logic                             out_ready
);

    logic                  load_en;
    logic                  grant_any;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic [DATA_WIDTH-1:0] grant_dat;
    logic [SEL_WIDTH-1:0]  last;
    logic [SEL_WIDTH-1:0]  cand;
    logic                  lock_act;

`ifdef MUX_RR_LOCK_EN
    assign lock_act = lock & mode;
`else
    assign lock_act = 1'b0;
`endif

    // The output register can take a new word when empty or being drained this cycle.
    assign load_en = ~out_valid | out_ready;

    // Grant decision: explicit select, locked channel, or first valid channel after last.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (load_en && !reset) begin
            if (!mode) begin
                // Out-of-range sel never matches any channel index, so it never grants.
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (sel == SEL_WIDTH'(i) && in_valid[i]) begin
                        grant_any = 1'b1;
                        grant_idx = sel;
                    end
                end
            end else if (lock_act) begin
                if (in_valid[last]) begin
                    grant_any = 1'b1;
                    grant_idx = last;
                end
            end else begin
                for (int k = 1; k <= NUM_INPUTS; k++) begin
                    cand = SEL_WIDTH'((int'(last) + k) % NUM_INPUTS);
                    if (!grant_any && in_valid[cand]) begin
                        grant_any = 1'b1;
                        grant_idx = cand;
                    end
                end
            end
        end
    end

    // Pick the granted channel's data word.
    always_comb begin
        grant_dat = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_idx == SEL_WIDTH'(i)) begin
                grant_dat = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // One-hot ready to the granted channel; grant_any is already gated by load_en and reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_any && grant_idx == SEL_WIDTH'(i)) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            last      <= SEL_WIDTH'(NUM_INPUTS - 1);
        end else if (load_en) begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_data  <= grant_dat;
                out_src   <= grant_idx;
                if (mode) begin
                    last <= grant_idx;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb_mux_rr_arb: vector table, directed corner sequences, then randomized traffic against a reference model.
// Inputs change 1 time unit after the rising edge; in_ready sampled mid-cycle, outputs 1 unit after the edge.
// The reference model works from channel distances to the last grant rather than a scan order.
module tb_mux_rr_arb;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode;
    logic [SW-1:0] sel;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_src;
    logic          out_valid;
    logic          out_ready;
`ifdef MUX_RR_LOCK_EN
    logic          lock;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_rr_arb #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
`ifdef MUX_RR_LOCK_EN
        .lock      (lock),
`endif
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic          rst;
        logic          md;
        logic [SW-1:0] s;
        logic [N-1:0]  v;
        logic          ordy;
        logic [N-1:0]  rdy;
        logic          ov;
        logic [SW-1:0] src;
        logic [DW-1:0] od;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic [SW-1:0] s,
                         input logic [N-1:0] v, input logic o);
        reset     = r;
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = o;
    endtask

    // One directed cycle: inputs already driven at edge+1.
    task automatic dcycle(input string name, input logic [N-1:0] rdy, input logic ov,
                          input logic [SW-1:0] src, input logic [DW-1:0] od);
        #3;
        check({name, "_in_ready"}, 32'(in_ready), 32'(rdy));
        @(posedge clk);
        #1;
        check({name, "_out_valid"}, 32'(out_valid), 32'(ov));
        check({name, "_out_src"}, 32'(out_src), 32'(src));
        check({name, "_out_data"}, 32'(out_data), 32'(od));
    endtask

    // Reference model state
    logic          m_ov;
    logic [DW-1:0] m_od;
    logic [SW-1:0] m_src;
    int            m_last;
    logic [DW-1:0] chd [N];

    initial begin
        logic          r, m, o, can_load, locked;
        logic [N-1:0]  v;
        int            s, win, best, d;
        logic [N-1:0]  exp_rdy;

        tbl[0]  = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'h0A00};
        tbl[2]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 16'h0A01};
        tbl[3]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 16'h0A02};
        tbl[4]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 16'h0A03};
        tbl[5]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'h0A00};
        tbl[6]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 16'h0A00};
        tbl[7]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 16'h0A00};
        tbl[8]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 16'h0A00};
        tbl[9]  = '{1'b0, 1'b1, 2'd0, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1, 16'h0A01};
        tbl[10] = '{1'b0, 1'b1, 2'd0, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3, 16'h0A03};
        tbl[11] = '{1'b0, 1'b1, 2'd0, 4'h9, 1'b1, 4'h1, 1'b1, 2'd0, 16'h0A00};
        tbl[12] = '{1'b0, 1'b1, 2'd0, 4'h9, 1'b1, 4'h8, 1'b1, 2'd3, 16'h0A03};
        tbl[13] = '{1'b0, 1'b0, 2'd2, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 16'h0A02};
        tbl[14] = '{1'b0, 1'b0, 2'd3, 4'h7, 1'b1, 4'h0, 1'b0, 2'd2, 16'h0A02};
        tbl[15] = '{1'b0, 1'b0, 2'd3, 4'h7, 1'b0, 4'h0, 1'b0, 2'd2, 16'h0A02};
        tbl[16] = '{1'b0, 1'b1, 2'd0, 4'hE, 1'b1, 4'h2, 1'b1, 2'd1, 16'h0A01};
        tbl[17] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 16'h0A01};
        tbl[18] = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0, 16'h0000};
        tbl[19] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'h0A00};
        tbl[20] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 16'h0A01};

        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 16'h0A00 + 16'(i);
`ifdef MUX_RR_LOCK_EN
        lock = 1'b0;
`endif
        #1;
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst, tbl[i].md, tbl[i].s, tbl[i].v, tbl[i].ordy);
            dcycle($sformatf("row%0d", i), tbl[i].rdy, tbl[i].ov, tbl[i].src, tbl[i].od);
        end

        // Explicit select of a distinct data word, then a select whose channel is idle.
        in_data[2*DW +: DW] = 16'hBEEF;
        drive(1'b0, 1'b0, 2'd2, 4'b0100, 1'b1);
        dcycle("sel2_beef", 4'b0100, 1'b1, 2'd2, 16'hBEEF);
        drive(1'b0, 1'b0, 2'd3, 4'b0000, 1'b1);
        dcycle("sel3_idle", 4'b0000, 1'b0, 2'd2, 16'hBEEF);

`ifdef MUX_RR_LOCK_EN
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 16'h0A00 + 16'(i);
        drive(1'b0, 1'b1, 2'd0, 4'b0010, 1'b1);
        dcycle("lock_pre", 4'b0010, 1'b1, 2'd1, 16'h0A01);
        lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1);
            dcycle($sformatf("lock_hold%0d", i), 4'b0010, 1'b1, 2'd1, 16'h0A01);
        end
        drive(1'b0, 1'b1, 2'd0, 4'b1101, 1'b1);
        dcycle("lock_idle", 4'b0000, 1'b0, 2'd1, 16'h0A01);
        lock = 1'b0;
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1);
        dcycle("lock_release", 4'b0100, 1'b1, 2'd2, 16'h0A02);
`endif

        // Randomized traffic against the reference model.
        m_ov = 1'b0; m_od = '0; m_src = '0; m_last = N - 1;
        for (int c = 0; c < 3000; c++) begin
            r = (c == 0) || ($urandom_range(0, 63) == 0);
            m = 1'($urandom_range(0, 1));
            s = $urandom_range(0, N - 1);
            v = N'($urandom_range(0, 15));
            o = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                chd[i] = DW'($urandom);
                in_data[i*DW +: DW] = chd[i];
            end
            locked = 1'b0;
`ifdef MUX_RR_LOCK_EN
            lock = ($urandom_range(0, 3) == 0);
            locked = lock & m;
`endif
            drive(r, m, SW'(s), v, o);

            win = -1;
            can_load = !m_ov || o;
            if (!r && can_load) begin
                if (!m) begin
                    if (s < N && ((v >> s) & 1) != 0) win = s;
                end else if (locked) begin
                    if (((v >> m_last) & 1) != 0) win = m_last;
                end else begin
                    best = N;
                    for (int i = 0; i < N; i++) begin
                        if (((v >> i) & 1) != 0) begin
                            d = (i - m_last - 1 + N) % N;
                            if (d < best) begin
                                best = d;
                                win = i;
                            end
                        end
                    end
                end
            end
            exp_rdy = (win >= 0) ? N'(1 << win) : '0;

            #3;
            check("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
            @(posedge clk);
            if (r) begin
                m_ov = 1'b0; m_od = '0; m_src = '0; m_last = N - 1;
            end else if (win >= 0) begin
                m_ov = 1'b1; m_od = chd[win]; m_src = SW'(win);
                if (m) m_last = win;
            end else if (can_load) begin
                m_ov = 1'b0;
            end
            #1;
            check("rand_out_valid", 32'(out_valid), 32'(m_ov));
            check("rand_out_src", 32'(out_src), 32'(m_src));
            check("rand_out_data", 32'(out_data), 32'(m_od));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
